// File: rtl/trap_ctrl_pkg.sv
// Shared RISC-V definitions for the M-mode trap controller.
package trap_ctrl_pkg;

  localparam int unsigned RV_XLEN = 64;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_t;

  // Synchronous exceptions plus interrupt causes (MSB set)
  typedef enum logic [RV_XLEN-1:0] {
    INSTR_ADDR_MISALIGNED = 64'd0,
    INSTR_ACCESS_FAULT    = 64'd1,
    ILLEGAL_INSTR         = 64'd2,
    BREAKPOINT            = 64'd3,
    LD_ADDR_MISALIGNED    = 64'd4,
    LD_ACCESS_FAULT       = 64'd5,
    ST_ADDR_MISALIGNED    = 64'd6,
    ST_ACCESS_FAULT       = 64'd7,
    ENV_CALL_UMODE        = 64'd8,
    ENV_CALL_SMODE        = 64'd9,
    ENV_CALL_MMODE        = 64'd11,
    IRQ_U_SOFT            = 64'h8000_0000_0000_0000,
    IRQ_S_SOFT            = 64'h8000_0000_0000_0001,
    IRQ_M_SOFT            = 64'h8000_0000_0000_0003,
    IRQ_U_TIMER           = 64'h8000_0000_0000_0004,
    IRQ_S_TIMER           = 64'h8000_0000_0000_0005,
    IRQ_M_TIMER           = 64'h8000_0000_0000_0007,
    IRQ_U_EXT             = 64'h8000_0000_0000_0008,
    IRQ_S_EXT             = 64'h8000_0000_0000_0009,
    IRQ_M_EXT             = 64'h8000_0000_0000_000B
  } ex_cause_t;

  // mip/mie bit indices
  localparam int unsigned IRQ_USI = 0;
  localparam int unsigned IRQ_SSI = 1;
  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_UTI = 4;
  localparam int unsigned IRQ_STI = 5;
  localparam int unsigned IRQ_MTI = 7;
  localparam int unsigned IRQ_UEI = 8;
  localparam int unsigned IRQ_SEI = 9;
  localparam int unsigned IRQ_MEI = 11;

  localparam logic [RV_XLEN-1:0] U_SW_INTR_MASK    = RV_XLEN'(1) << IRQ_USI;
  localparam logic [RV_XLEN-1:0] S_SW_INTR_MASK    = RV_XLEN'(1) << IRQ_SSI;
  localparam logic [RV_XLEN-1:0] M_SW_INTR_MASK    = RV_XLEN'(1) << IRQ_MSI;
  localparam logic [RV_XLEN-1:0] U_TIMER_INTR_MASK = RV_XLEN'(1) << IRQ_UTI;
  localparam logic [RV_XLEN-1:0] S_TIMER_INTR_MASK = RV_XLEN'(1) << IRQ_STI;
  localparam logic [RV_XLEN-1:0] M_TIMER_INTR_MASK = RV_XLEN'(1) << IRQ_MTI;
  localparam logic [RV_XLEN-1:0] U_EXT_INTR_MASK   = RV_XLEN'(1) << IRQ_UEI;
  localparam logic [RV_XLEN-1:0] S_EXT_INTR_MASK   = RV_XLEN'(1) << IRQ_SEI;
  localparam logic [RV_XLEN-1:0] M_EXT_INTR_MASK   = RV_XLEN'(1) << IRQ_MEI;
  localparam logic [RV_XLEN-1:0] ALL_INTR_MASK =
    U_SW_INTR_MASK | S_SW_INTR_MASK | M_SW_INTR_MASK |
    U_TIMER_INTR_MASK | S_TIMER_INTR_MASK | M_TIMER_INTR_MASK |
    U_EXT_INTR_MASK | S_EXT_INTR_MASK | M_EXT_INTR_MASK;

  // mstatus field positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LSB  = 11;
  localparam int unsigned MSTATUS_MPP_MSB  = 12;

  typedef struct packed {
    logic        sd;
    logic [26:0] wpri3;
    logic [1:0]  sxl;
    logic [1:0]  uxl;
    logic [8:0]  wpri2;
    logic        tsr;
    logic        tw;
    logic        tvm;
    logic        mxr;
    logic        sum;
    logic        mprv;
    logic [1:0]  xs;
    logic [1:0]  fs;
    logic [1:0]  mpp;
    logic [1:0]  wpri1;
    logic        spp;
    logic        mpie;
    logic        ube;
    logic        spie;
    logic        upie;
    logic        mie;
    logic        wpri0;
    logic        sie;
    logic        uie;
  } status_rv64_t;

  typedef enum logic [1:0] {
    CSR_MSTATUS = 2'd0,
    CSR_MEPC    = 2'd1,
    CSR_MCAUSE  = 2'd2,
    CSR_MTVAL   = 2'd3
  } csr_sel_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } trap_state_t;

endpackage

// File: rtl/trap_irq_arb.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > SEI > SSI > STI > UEI > USI > UTI.
module trap_irq_arb
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = RV_XLEN
) (
  input  logic [XLEN-1:0] i_pending,
  input  logic [XLEN-1:0] i_enable,
  output logic            o_irq_valid_c,
  output logic [XLEN-1:0] o_irq_cause_c
);

  logic [XLEN-1:0] w_act;
  logic [3:0]      w_code;
  logic            w_unused;

  assign w_act    = i_pending & i_enable & XLEN'(ALL_INTR_MASK);
  assign w_unused = ^w_act;

  // Pick the highest-priority active interrupt
  always_comb begin
    o_irq_valid_c = 1'b1;
    w_code        = 4'd0;
    if      (w_act[IRQ_MEI]) w_code = 4'(IRQ_MEI);
    else if (w_act[IRQ_MSI]) w_code = 4'(IRQ_MSI);
    else if (w_act[IRQ_MTI]) w_code = 4'(IRQ_MTI);
    else if (w_act[IRQ_SEI]) w_code = 4'(IRQ_SEI);
    else if (w_act[IRQ_SSI]) w_code = 4'(IRQ_SSI);
    else if (w_act[IRQ_STI]) w_code = 4'(IRQ_STI);
    else if (w_act[IRQ_UEI]) w_code = 4'(IRQ_UEI);
    else if (w_act[IRQ_USI]) w_code = 4'(IRQ_USI);
    else if (w_act[IRQ_UTI]) w_code = 4'(IRQ_UTI);
    else                     o_irq_valid_c = 1'b0;
  end

  assign o_irq_cause_c = o_irq_valid_c ? {1'b1, (XLEN-1)'(w_code)} : '0;

endmodule

// File: rtl/trap_ctrl.sv
// M-mode trap controller: trap entry / mret, then flush -> drain -> redirect.
// Optional TRAP_VECTORED_EN: vectored interrupt targets when mtvec mode is 1.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = RV_XLEN,
  parameter logic [1:0]  RST_PRIV = PRIV_M
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_cause_i,
  input  logic [XLEN-1:0] ex_tval_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] irq_pending_i,
  input  logic [XLEN-1:0] irq_enable_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            csr_we_i,
  input  logic [1:0]      csr_sel_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  input  logic            drained_i,
  output logic            ready_o,
  output logic            flush_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [1:0]      priv_o,
  output logic [XLEN-1:0] mstatus_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o
);

  trap_state_t     r_state;
  priv_t           r_priv;
  priv_t           r_mpp;
  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_target;
  logic            r_ready;
  logic            r_flush;
  logic            r_redirect;

  logic            w_irq_valid;
  logic [XLEN-1:0] w_irq_cause;
  logic            w_in_m;
  logic            w_accept;
  logic            w_take_exc;
  logic            w_take_mret;
  logic            w_take_irq;
  logic [XLEN-1:0] w_cause;
  logic [XLEN-1:0] w_tval;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_irq_target;
  logic [1:0]      w_wpp;
  status_rv64_t    w_status;

  trap_irq_arb #(.XLEN(XLEN)) u_irq_arb (
    .i_pending     (irq_pending_i),
    .i_enable      (irq_enable_i),
    .o_irq_valid_c (w_irq_valid),
    .o_irq_cause_c (w_irq_cause)
  );

  // Accept decode: exception (incl. mret outside M) > mret > interrupt
  assign w_in_m      = (r_priv == PRIV_M);
  assign w_accept    = (r_state == IDLE) && instr_valid_i;
  assign w_take_exc  = w_accept && (ex_valid_i || (mret_i && !w_in_m));
  assign w_take_mret = w_accept && !ex_valid_i && mret_i && w_in_m;
  assign w_take_irq  = w_accept && !ex_valid_i && !mret_i && w_irq_valid &&
                       (!w_in_m || r_mie);

  assign w_cause = w_take_irq ? w_irq_cause :
                   (ex_valid_i ? ex_cause_i : XLEN'(ILLEGAL_INSTR));
  assign w_tval  = (w_take_exc && ex_valid_i) ? ex_tval_i : '0;
  assign w_base  = mtvec_i & ~XLEN'(3);

`ifdef TRAP_VECTORED_EN
  assign w_irq_target = (mtvec_i[1:0] == 2'b01) ? (w_base + (w_irq_cause << 2)) : w_base;
`else
  assign w_irq_target = w_base;
`endif

  // Reserved mpp encoding collapses to U
  assign w_wpp = (csr_wdata_i[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB] == 2'b10) ? 2'b00 :
                 csr_wdata_i[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB];

  // Trap state machine and CSR state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_priv     <= priv_t'(RST_PRIV);
      r_mpp      <= PRIV_M;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_target   <= '0;
      r_ready    <= 1'b1;
      r_flush    <= 1'b0;
      r_redirect <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_take_exc || w_take_irq) begin
            r_mepc   <= ex_pc_i & ~XLEN'(1);
            r_mcause <= w_cause;
            r_mtval  <= w_tval;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            r_mpp    <= r_priv;
            r_priv   <= PRIV_M;
            r_target <= w_take_irq ? w_irq_target : w_base;
            r_state  <= FLUSH;
            r_ready  <= 1'b0;
            r_flush  <= 1'b1;
          end else if (w_take_mret) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
            r_priv   <= r_mpp;
            r_mpp    <= PRIV_U;
            r_target <= r_mepc;
            r_state  <= FLUSH;
            r_ready  <= 1'b0;
            r_flush  <= 1'b1;
          end else if (csr_we_i) begin
            case (csr_sel_t'(csr_sel_i))
              CSR_MSTATUS: begin
                r_mie  <= csr_wdata_i[MSTATUS_MIE_BIT];
                r_mpie <= csr_wdata_i[MSTATUS_MPIE_BIT];
                r_mpp  <= priv_t'(w_wpp);
              end
              CSR_MEPC:   r_mepc   <= csr_wdata_i & ~XLEN'(1);
              CSR_MCAUSE: r_mcause <= csr_wdata_i;
              CSR_MTVAL:  r_mtval  <= csr_wdata_i;
              default: ;
            endcase
          end
        end
        FLUSH: begin
          if (drained_i) begin
            r_state    <= REDIRECT;
            r_flush    <= 1'b0;
            r_redirect <= 1'b1;
          end
        end
        REDIRECT: begin
          r_state    <= IDLE;
          r_redirect <= 1'b0;
          r_ready    <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_flush    <= 1'b0;
          r_redirect <= 1'b0;
          r_ready    <= 1'b1;
        end
      endcase
    end
  end

  // mstatus view with only mie/mpie/mpp live
  always_comb begin
    w_status      = '0;
    w_status.mie  = r_mie;
    w_status.mpie = r_mpie;
    w_status.mpp  = r_mpp;
  end

  assign ready_o          = r_ready;
  assign flush_o          = r_flush;
  assign redirect_valid_o = r_redirect;
  assign redirect_pc_o    = r_target;
  assign priv_o           = r_priv;
  assign mstatus_o        = XLEN'(w_status);
  assign mepc_o           = r_mepc;
  assign mcause_o         = r_mcause;
  assign mtval_o          = r_mtval;

endmodule
